// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter that shares one external combinational ALU between two requesters.
// One operation is in flight at a time; the result is registered and returned on a tagged response channel.
module alu_issue_arbiter #(
    parameter int N = 16,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req0_cin,
    input  logic [M-1:0] req0_mode,
    input  logic         req0_acc,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic         req1_cin,
    input  logic [M-1:0] req1_mode,
    input  logic         req1_acc,

    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic         alu_cin,
    output logic [M-1:0] alu_mode,
    input  logic [N-1:0] alu_y,
    input  logic         alu_cout,
    input  logic         alu_ovf,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_y,
    output logic         rsp_cout,
    output logic         rsp_ovf
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } stateT;

    stateT          state_q, state_d;
    logic           lastGrant_q;
    logic [N-1:0]   opA_q, opB_q;
    logic           opCin_q;
    logic [M-1:0]   opMode_q;
    logic           opId_q;
    logic [N-1:0]   acc_q;
    logic [N-1:0]   rspY_q;
    logic           rspCout_q, rspOvf_q, rspId_q, rspValid_q;

    logic           grantId;
    logic           accept;
    logic [N-1:0]   selA, selB;
    logic           selCin;
    logic [M-1:0]   selMode;

    // When both requesters are valid the one served least recently wins; a lone requester always wins.
    always_comb begin
        grantId = req1_valid;
        if (req0_valid && req1_valid) begin
            grantId = ~lastGrant_q;
        end
        req0_ready = !rst && (state_q == IDLE) && req0_valid && !grantId;
        req1_ready = !rst && (state_q == IDLE) && req1_valid && grantId;
        accept     = req0_ready | req1_ready;
    end

    always_comb begin
        selA    = req0_acc ? acc_q : req0_a;
        selB    = req0_b;
        selCin  = req0_cin;
        selMode = req0_mode;
        if (grantId) begin
            selA    = req1_acc ? acc_q : req1_a;
            selB    = req1_b;
            selCin  = req1_cin;
            selMode = req1_mode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The ALU settles during EXEC, so its outputs are captured into both the response and the shared accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastGrant_q <= 1'b1;
            opA_q       <= '0;
            opB_q       <= '0;
            opCin_q     <= 1'b0;
            opMode_q    <= '0;
            opId_q      <= 1'b0;
            acc_q       <= '0;
            rspY_q      <= '0;
            rspCout_q   <= 1'b0;
            rspOvf_q    <= 1'b0;
            rspId_q     <= 1'b0;
            rspValid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        opA_q       <= selA;
                        opB_q       <= selB;
                        opCin_q     <= selCin;
                        opMode_q    <= selMode;
                        opId_q      <= grantId;
                        lastGrant_q <= grantId;
                    end
                end
                EXEC: begin
                    rspY_q     <= alu_y;
                    rspCout_q  <= alu_cout;
                    rspOvf_q   <= alu_ovf;
                    rspId_q    <= opId_q;
                    acc_q      <= alu_y;
                    rspValid_q <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rspValid_q <= 1'b0;
                    end
                end
                default: begin
                    rspValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign alu_a     = opA_q;
    assign alu_b     = opB_q;
    assign alu_cin   = opCin_q;
    assign alu_mode  = opMode_q;

    assign rsp_valid = rspValid_q;
    assign rsp_id    = rspId_q;
    assign rsp_y     = rspY_q;
    assign rsp_cout  = rspCout_q;
    assign rsp_ovf   = rspOvf_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Scoreboard bench for alu_issue_arbiter: a transaction-level model predicts grants and results,
// a separate monitor compares every response the arbiter presents against the queued expectation.
module tb_alu_issue_arbiter;

    typedef struct packed {
        logic        valid;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [3:0]  mode;
        logic        acc;
    } reqT;

    typedef struct {
        int          cyc;
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [3:0]  mode;
        logic [15:0] y;
        logic        cout;
        logic        ovf;
    } expT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_cin = 1'b0, req1_cin = 1'b0;
    logic [3:0]  req0_mode = '0, req1_mode = '0;
    logic        req0_acc = 1'b0, req1_acc = 1'b0;
    logic [15:0] alu_a, alu_b, alu_y;
    logic        alu_cin, alu_cout, alu_ovf;
    logic [3:0]  alu_mode;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_cout, rsp_ovf;
    logic [15:0] rsp_y;

    int          total = 0;
    int          bad = 0;
    int          cycleNo = 0;
    expT         expQ[$];
    logic [15:0] modelAcc = '0;
    logic        modelLast = 1'b1;

    always #5 clk = ~clk;

    alu_issue_arbiter #(.N(16), .M(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_cin(req0_cin), .req0_mode(req0_mode), .req0_acc(req0_acc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_cin(req1_cin), .req1_mode(req1_mode), .req1_acc(req1_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_mode(alu_mode),
        .alu_y(alu_y), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
    );

    // Behavioural ALU the arbiter drives; result packed as {cout, ovf, y}.
    function automatic logic [17:0] aluFn(input logic [3:0] mode, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin);
        logic [16:0] s;
        logic [15:0] y;
        logic        c, v;
        s = '0; y = '0; c = 1'b0; v = 1'b0;
        case (mode)
            4'd0:  y = a & b;
            4'd1:  y = a | b;
            4'd2:  y = a ^ b;
            4'd3:  begin y = {a[15], a[15:1]}; c = a[0]; end
            4'd4:  begin
                       s = {1'b0, a} + {1'b0, b} + {16'd0, cin};
                       y = s[15:0]; c = s[16];
                       v = (a[15] == b[15]) && (y[15] != a[15]);
                   end
            4'd5:  begin
                       s = {1'b0, a} + {1'b0, ~b} + 17'd1;
                       y = s[15:0]; c = s[16];
                       v = (a[15] != b[15]) && (y[15] != a[15]);
                   end
            4'd6:  begin y = {a[14:0], 1'b0}; c = a[15]; end
            4'd7:  begin y = {1'b0, a[15:1]}; c = a[0]; end
            4'd8:  y = ~a;
            4'd9:  begin s = {1'b0, a} + 17'd1; y = s[15:0]; c = s[16]; end
            4'd10: begin s = {1'b0, a} + 17'h0FFFF; y = s[15:0]; c = s[16]; end
            4'd11: y = b;
            4'd12: y = a;
            4'd13: y = ~(a & b);
            4'd14: begin s = {1'b0, a} + {1'b0, b}; y = s[15:0]; c = s[16]; end
            default: y = a ^ {b[7:0], b[15:8]};
        endcase
        return {c, v, y};
    endfunction

    always_comb begin
        {alu_cout, alu_ovf, alu_y} = aluFn(alu_mode, alu_a, alu_b, alu_cin);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleNo);
        end
    endtask

    function automatic reqT mkReq(input logic v, input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic [3:0] mode, input logic acc);
        reqT r;
        r.valid = v; r.a = a; r.b = b; r.cin = cin; r.mode = mode; r.acc = acc;
        return r;
    endfunction

    function automatic reqT randReq();
        return mkReq($urandom_range(0, 99) < 60, 16'($urandom), 16'($urandom),
                     1'($urandom), 4'($urandom), $urandom_range(0, 99) < 30);
    endfunction

    // One clock cycle: drive inputs after the falling edge, then let the model decide who should be
    // granted. The arbiter is free exactly when no response is outstanding.
    task automatic applyStimulus(input reqT r0, input reqT r1, input logic rr, input logic rs);
        int   g;
        reqT  w;
        logic [17:0] res;
        expT  e;
        @(negedge clk);
        #1;
        cycleNo++;
        rst = rs;
        req0_valid = r0.valid; req0_a = r0.a; req0_b = r0.b;
        req0_cin = r0.cin; req0_mode = r0.mode; req0_acc = r0.acc;
        req1_valid = r1.valid; req1_a = r1.a; req1_b = r1.b;
        req1_cin = r1.cin; req1_mode = r1.mode; req1_acc = r1.acc;
        rsp_ready = rr;
        #2;
        g = -1;
        if (rs) begin
            expQ.delete();
            modelAcc  = '0;
            modelLast = 1'b1;
        end else if (expQ.size() == 0) begin
            if (r0.valid && r1.valid) g = modelLast ? 0 : 1;
            else if (r0.valid)        g = 0;
            else if (r1.valid)        g = 1;
        end
        checkOutput("req0_ready", 32'(req0_ready), 32'(g == 0));
        checkOutput("req1_ready", 32'(req1_ready), 32'(g == 1));
        if (g >= 0) begin
            w      = (g == 1) ? r1 : r0;
            e.cyc  = cycleNo;
            e.id   = (g == 1);
            e.a    = w.acc ? modelAcc : w.a;
            e.b    = w.b;
            e.cin  = w.cin;
            e.mode = w.mode;
            res    = aluFn(e.mode, e.a, e.b, e.cin);
            {e.cout, e.ovf, e.y} = res;
            expQ.push_back(e);
            modelAcc  = e.y;
            modelLast = e.id;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(mkReq(0, 0, 0, 0, 0, 0), mkReq(0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    endtask

    task automatic checkRsp(input logic [15:0] y, input logic id, input logic cout, input logic ovf);
        checkOutput("plan_valid", 32'(rsp_valid), 32'd1);
        checkOutput("plan_y", 32'(rsp_y), 32'(y));
        checkOutput("plan_id", 32'(rsp_id), 32'(id));
        checkOutput("plan_cout", 32'(rsp_cout), 32'(cout));
        checkOutput("plan_ovf", 32'(rsp_ovf), 32'(ovf));
    endtask

    // Monitor: samples just before each rising edge and compares whatever the arbiter presents.
    initial begin
        expT e;
        int  age;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                checkOutput("rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
            end else if (expQ.size() == 0) begin
                checkOutput("spurious_rsp_valid", 32'(rsp_valid), 32'd0);
            end else begin
                e   = expQ[0];
                age = cycleNo - e.cyc;
                if (age < 2) begin
                    checkOutput("early_rsp_valid", 32'(rsp_valid), 32'd0);
                end
                if (age == 1) begin
                    checkOutput("exec_alu_a", 32'(alu_a), 32'(e.a));
                    checkOutput("exec_alu_b", 32'(alu_b), 32'(e.b));
                    checkOutput("exec_alu_cin", 32'(alu_cin), 32'(e.cin));
                    checkOutput("exec_alu_mode", 32'(alu_mode), 32'(e.mode));
                end else if (age >= 2) begin
                    checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
                    if (rsp_valid) begin
                        checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
                        checkOutput("rsp_y", 32'(rsp_y), 32'(e.y));
                        checkOutput("rsp_cout", 32'(rsp_cout), 32'(e.cout));
                        checkOutput("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
                        if (rsp_ready) void'(expQ.pop_front());
                    end else begin
                        void'(expQ.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        reqT idle;
        idle = mkReq(0, 0, 0, 0, 0, 0);
        #3;
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_y", 32'(rsp_y), 32'd0);
        checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("reset_alu_a", 32'(alu_a), 32'd0);
        checkOutput("reset_alu_mode", 32'(alu_mode), 32'd0);
        applyStimulus(mkReq(1, 16'h1111, 16'h2222, 0, 4'd4, 0), mkReq(1, 0, 0, 0, 0, 0), 1'b1, 1'b1);

        // Simple add from req0, then subtract from req1.
        applyStimulus(mkReq(1, 16'h0003, 16'h0004, 0, 4'd4, 0), idle, 1'b1, 1'b0);
        idleCycles(2);
        checkRsp(16'h0007, 1'b0, 1'b0, 1'b0);
        idleCycles(1);
        applyStimulus(idle, mkReq(1, 16'h0005, 16'h0007, 0, 4'd5, 0), 1'b1, 1'b0);
        idleCycles(2);
        checkRsp(16'hFFFE, 1'b1, 1'b0, 1'b0);
        idleCycles(2);

        // Both requesters continuously valid straight out of reset.
        applyStimulus(idle, idle, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++)
            applyStimulus(mkReq(1, 16'(i), 16'h0010, 0, 4'd4, 0), mkReq(1, 16'h0100, 16'(i), 1, 4'd4, 0), 1'b1, 1'b0);
        idleCycles(3);

        // Overflowing add, then chain through the accumulator with an arithmetic shift.
        applyStimulus(mkReq(1, 16'h7FFF, 16'h0001, 0, 4'd4, 0), idle, 1'b1, 1'b0);
        idleCycles(2);
        checkRsp(16'h8000, 1'b0, 1'b0, 1'b1);
        applyStimulus(idle, mkReq(1, 16'h1234, 16'h0000, 0, 4'd3, 1), 1'b1, 1'b0);
        idleCycles(1);
        checkOutput("chain_alu_a", 32'(alu_a), 32'h8000);
        idleCycles(1);
        checkRsp(16'hC000, 1'b1, 1'b0, 1'b0);
        idleCycles(2);

        // Back-pressure on the response while both requesters wait.
        for (int i = 0; i < 9; i++)
            applyStimulus(mkReq(1, 16'h00AA, 16'h0055, 0, 4'd1, 0), mkReq(1, 16'h0F0F, 16'h00FF, 0, 4'd0, 0), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            applyStimulus(mkReq(1, 16'h00AA, 16'h0055, 0, 4'd1, 0), mkReq(1, 16'h0F0F, 16'h00FF, 0, 4'd0, 0), 1'b1, 1'b0);
        idleCycles(3);

        // Reset during EXEC discards the transaction and clears the accumulator.
        applyStimulus(mkReq(1, 16'h0005, 16'h0006, 0, 4'd4, 0), idle, 1'b1, 1'b0);
        applyStimulus(idle, idle, 1'b1, 1'b1);
        applyStimulus(idle, idle, 1'b1, 1'b0);
        checkOutput("after_reset_valid", 32'(rsp_valid), 32'd0);
        applyStimulus(mkReq(1, 16'h1111, 16'h0002, 0, 4'd4, 1), idle, 1'b1, 1'b0);
        idleCycles(2);
        checkRsp(16'h0002, 1'b0, 1'b0, 1'b0);
        idleCycles(2);

        for (int i = 0; i < 600; i++)
            applyStimulus(randReq(), randReq(), $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 2);
        idleCycles(6);
        checkOutput("outstanding_at_end", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
